// File: rtl/iig_pkg.sv
// Shared integral-image definitions: frame geometry, word widths,
// rectangle-sum FSM states, corner signs and the xy-to-address helper.
package iig_pkg;

    localparam int IIG_IMG_W  = 80;
    localparam int IIG_IMG_H  = 60;
    localparam int IIG_ADDR_W = 13;
    localparam int IIG_DATA_W = 21;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLOT_A,
        ST_SLOT_B,
        ST_SLOT_C,
        ST_SLOT_D,
        ST_DRAIN,
        ST_DONE
    } rectState_t;

    typedef enum logic {
        SIGN_ADD = 1'b0,
        SIGN_SUB = 1'b1
    } cornerSign_t;

    // y*80 + x built from shifts only: y*80 = (y<<6) + (y<<4)
    function automatic logic [IIG_ADDR_W-1:0] xyToAddr(
        input logic [6:0] x,
        input logic [5:0] y
    );
        logic [IIG_ADDR_W-1:0] yw;
        yw = IIG_ADDR_W'(y);
        return (yw << 6) + (yw << 4) + IIG_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/iig_rect_acc.sv
// Read-return tag pipeline and signed corner accumulator
// for the rectangle-sum engine.
module iig_rect_acc
    import iig_pkg::*;
#(
    parameter int DATA_W = IIG_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iClear,
    input  logic              iRdreq,
    input  cornerSign_t       iSign,
    input  logic [DATA_W-1:0] iData,
    output logic [DATA_W-1:0] oSum
);

    logic        tagValid [RD_LAT];
    cornerSign_t tagSign  [RD_LAT];

    logic signed [DATA_W:0] acc;
    logic signed [DATA_W:0] dataExt;
    logic                   unusedAccMsb;

    assign dataExt = $signed({1'b0, iData});

    // Tags follow each strobe so that returning words meet their sign
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tagValid[i] <= 1'b0;
                tagSign[i]  <= SIGN_ADD;
            end
            acc <= '0;
        end else begin
            tagValid[0] <= iRdreq;
            tagSign[0]  <= iSign;
            for (int i = 1; i < RD_LAT; i++) begin
                tagValid[i] <= tagValid[i-1];
                tagSign[i]  <= tagSign[i-1];
            end
            if (iClear) begin
                acc <= '0;
            end else if (tagValid[RD_LAT-1]) begin
                if (tagSign[RD_LAT-1] == SIGN_SUB) begin
                    acc <= acc - dataExt;
                end else begin
                    acc <= acc + dataExt;
                end
            end
        end
    end

    assign oSum         = acc[DATA_W-1:0];
    assign unusedAccMsb = acc[DATA_W];

endmodule

// File: rtl/iig_rect_sum.sv
// Rectangle-sum engine over the integral-image BRAM (D - B - C + A).
// Optional request bounds check: IIG_RECT_BOUNDS_CHECK_EN.
module iig_rect_sum
    import iig_pkg::*;
#(
    parameter int IMG_W  = IIG_IMG_W,
    parameter int IMG_H  = IIG_IMG_H,
    parameter int ADDR_W = IIG_ADDR_W,
    parameter int DATA_W = IIG_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [6:0]        iX,
    input  logic [5:0]        iY,
    input  logic [6:0]        iW,
    input  logic [5:0]        iH,
    output logic              oRdreq_to_IIGBRAM,
    output logic [ADDR_W-1:0] oAddr_to_IIGBRAM,
    input  logic [DATA_W-1:0] iData_from_IIGBRAM,
    output logic              oBusy,
    output logic              oValid,
    output logic [DATA_W-1:0] oSum,
    output logic              oError
);

    rectState_t state;
    rectState_t nextState;

    logic [6:0]        xReg;
    logic [6:0]        wReg;
    logic [5:0]        yReg;
    logic [5:0]        hReg;
    logic [1:0]        drainCnt;
    logic [DATA_W-1:0] accSum;
    logic [DATA_W-1:0] sumHold;

    logic              accept;
    logic              skip;
    logic              rdreq;
    logic [ADDR_W-1:0] addr;
    cornerSign_t       sign;

    logic [6:0] xLeft;
    logic [6:0] xRight;
    logic [5:0] yTop;
    logic [5:0] yBot;
    logic       hasLeft;
    logic       hasTop;

    assign accept  = iStart && (state == ST_IDLE || state == ST_DONE);
    assign xLeft   = xReg - 7'd1;
    assign xRight  = xReg + wReg - 7'd1;
    assign yTop    = yReg - 6'd1;
    assign yBot    = yReg + hReg - 6'd1;
    assign hasLeft = (xReg != 7'd0);
    assign hasTop  = (yReg != 6'd0);

`ifdef IIG_RECT_BOUNDS_CHECK_EN
    logic reqBad;
    logic errReg;
    logic errHold;

    assign reqBad = (iW == 7'd0) || (iH == 6'd0)
                 || (({1'b0, iX} + {1'b0, iW}) > 8'(IMG_W))
                 || (({1'b0, iY} + {1'b0, iH}) > 7'(IMG_H));

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            errReg  <= 1'b0;
            errHold <= 1'b0;
        end else begin
            if (state == ST_DONE) errHold <= errReg;
            if (accept)           errReg  <= reqBad;
        end
    end

    assign skip   = errReg;
    assign oError = (state == ST_DONE) ? errReg : errHold;
`else
    localparam int unusedDims = IMG_W + IMG_H;

    assign skip   = 1'b0;
    assign oError = 1'b0;
`endif

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state    <= ST_IDLE;
            xReg     <= '0;
            yReg     <= '0;
            wReg     <= '0;
            hReg     <= '0;
            drainCnt <= '0;
            sumHold  <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                xReg <= iX;
                yReg <= iY;
                wReg <= iW;
                hReg <= iH;
            end
            if (state == ST_DRAIN) drainCnt <= drainCnt + 2'd1;
            else                   drainCnt <= '0;
            if (state == ST_DONE)  sumHold  <= accSum;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            ST_IDLE:   if (iStart) nextState = ST_SLOT_A;
            ST_SLOT_A: nextState = ST_SLOT_B;
            ST_SLOT_B: nextState = ST_SLOT_C;
            ST_SLOT_C: nextState = ST_SLOT_D;
            ST_SLOT_D: nextState = ST_DRAIN;
            ST_DRAIN:  if (drainCnt == 2'(RD_LAT - 1)) nextState = ST_DONE;
            ST_DONE:   nextState = iStart ? ST_SLOT_A : ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    // Missing corners (coordinate -1) issue no read and contribute zero
    always_comb begin
        rdreq = 1'b0;
        addr  = '0;
        sign  = SIGN_ADD;
        unique case (state)
            ST_SLOT_A: if (hasLeft && hasTop && !skip) begin
                rdreq = 1'b1;
                addr  = ADDR_W'(xyToAddr(xLeft, yTop));
            end
            ST_SLOT_B: if (hasTop && !skip) begin
                rdreq = 1'b1;
                sign  = SIGN_SUB;
                addr  = ADDR_W'(xyToAddr(xRight, yTop));
            end
            ST_SLOT_C: if (hasLeft && !skip) begin
                rdreq = 1'b1;
                sign  = SIGN_SUB;
                addr  = ADDR_W'(xyToAddr(xLeft, yBot));
            end
            ST_SLOT_D: if (!skip) begin
                rdreq = 1'b1;
                addr  = ADDR_W'(xyToAddr(xRight, yBot));
            end
            default: ;
        endcase
    end

    iig_rect_acc #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) uAcc (
        .iClk   (iClk),
        .iReset (iReset),
        .iClear (accept),
        .iRdreq (rdreq),
        .iSign  (sign),
        .iData  (iData_from_IIGBRAM),
        .oSum   (accSum)
    );

    assign oRdreq_to_IIGBRAM = rdreq;
    assign oAddr_to_IIGBRAM  = addr;
    assign oBusy             = (state != ST_IDLE) && (state != ST_DONE);
    assign oValid            = (state == ST_DONE);
    assign oSum              = oValid ? accSum : sumHold;

endmodule

// File: tb/tb_iig_rect_sum.sv
// Self-checking bench for iig_rect_sum: BRAM model, cycle-level
// reference model from corner definitions, and directed vectors.
module tb_iig_rect_sum;

    localparam int RD_LAT = 1;
    localparam int VLAT   = 5 + RD_LAT;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iStart;
    logic [6:0]  iX;
    logic [5:0]  iY;
    logic [6:0]  iW;
    logic [5:0]  iH;
    logic        oRdreq;
    logic [12:0] oAddr;
    logic [20:0] rdData;
    logic        oBusy;
    logic        oValid;
    logic [20:0] oSum;
    logic        oError;

    iig_rect_sum #(.RD_LAT(RD_LAT)) dut (
        .iClk               (iClk),
        .iReset             (iReset),
        .iStart             (iStart),
        .iX                 (iX),
        .iY                 (iY),
        .iW                 (iW),
        .iH                 (iH),
        .oRdreq_to_IIGBRAM  (oRdreq),
        .oAddr_to_IIGBRAM   (oAddr),
        .iData_from_IIGBRAM (rdData),
        .oBusy              (oBusy),
        .oValid             (oValid),
        .oSum               (oSum),
        .oError             (oError)
    );

    always #5 iClk = ~iClk;

    logic [20:0] mem [4800];
    int          fv;

    always @(posedge iClk) begin
        if (oRdreq) rdData <= (oAddr < 13'd4800) ? mem[oAddr] : '0;
    end

    task automatic fill(input int v);
        for (int y = 0; y < 60; y++)
            for (int x = 0; x < 80; x++)
                mem[y*80 + x] = 21'(v * (x + 1) * (y + 1));
        fv = v;
    endtask

    int passCnt  = 0;
    int checkCnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checkCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: request age since acceptance plus pixel-level sum
    bit mActive = 0;
    int mAge    = 0;
    int mX, mY, mW, mH, mSum;
    bit mRej;

    always @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            mActive = 0;
            mAge    = 0;
        end else if (iStart && (!mActive || mAge == VLAT)) begin
            mActive = 1;
            mAge    = 1;
            mX = iX; mY = iY; mW = iW; mH = iH;
`ifdef IIG_RECT_BOUNDS_CHECK_EN
            mRej = (mW == 0) || (mH == 0) || (mX + mW > 80) || (mY + mH > 60);
`else
            mRej = 0;
`endif
            mSum = 0;
            if (!mRej)
                for (int y = mY; y < mY + mH; y++)
                    for (int x = mX; x < mX + mW; x++)
                        mSum += fv;
        end else if (mActive) begin
            mAge++;
            if (mAge > VLAT) mActive = 0;
        end
    end

    task automatic cornerExp(output bit rd, output int a);
        int x1, y1;
        x1 = mX + mW - 1;
        y1 = mY + mH - 1;
        rd = 0;
        a  = 0;
        if (mActive && !mRej) begin
            case (mAge)
                1: if (mX > 0 && mY > 0) begin rd = 1; a = (mY-1)*80 + mX-1; end
                2: if (mY > 0) begin rd = 1; a = (mY-1)*80 + x1; end
                3: if (mX > 0) begin rd = 1; a = y1*80 + mX-1; end
                4: begin rd = 1; a = y1*80 + x1; end
                default: ;
            endcase
        end
    endtask

    always @(posedge iClk) begin
        bit eRd;
        int eAddr;
        #2;
        cornerExp(eRd, eAddr);
        chk("busy", oBusy, int'(mActive && mAge < VLAT));
        chk("valid", oValid, int'(mActive && mAge == VLAT));
        chk("rdreq", oRdreq, int'(eRd));
        if (eRd) chk("addr", oAddr, eAddr);
        if (mActive && mAge == VLAT) begin
            chk("sum", oSum, mSum);
            chk("error", oError, int'(mRej));
        end
    end

    task automatic doReq(input int x, y, w, h);
        @(negedge iClk);
        iX = 7'(x); iY = 6'(y); iW = 7'(w); iH = 6'(h);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        iX = ~iX; iY = ~iY; iW = ~iW; iH = ~iH;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        iReset = 1'b1;
        iStart = 1'b0;
        iX = '0; iY = '0; iW = '0; iH = '0;
        fill(1);
        repeat (3) @(negedge iClk);
        chk("rst_busy", oBusy, 0);
        chk("rst_valid", oValid, 0);
        chk("rst_sum", oSum, 0);
        chk("rst_err", oError, 0);
        chk("rst_rdreq", oRdreq, 0);
        chk("rst_addr", oAddr, 0);
        iReset = 1'b0;
        repeat (2) @(negedge iClk);

        doReq(10, 5, 4, 3);
        chk("r1_a", oAddr, 329);
        @(negedge iClk) chk("r1_b", oAddr, 333);
        @(negedge iClk) chk("r1_c", oAddr, 569);
        @(negedge iClk) chk("r1_d", oAddr, 573);
        @(negedge iClk) chk("r1_early", oValid, 0);
        @(negedge iClk);
        chk("r1_valid", oValid, 1);
        chk("r1_sum", oSum, 12);
        chk("r1_err", oError, 0);
        @(negedge iClk) chk("r1_hold", oSum, 12);

        doReq(0, 0, 1, 1);
        chk("r2_noA", oRdreq, 0);
        repeat (3) @(negedge iClk);
        chk("r2_d", oAddr, 0);
        chk("r2_drd", oRdreq, 1);
        repeat (2) @(negedge iClk);
        chk("r2_sum", oSum, 1);

        doReq(0, 0, 80, 60);
        repeat (3) @(negedge iClk);
        chk("r3_d", oAddr, 4799);
        repeat (2) @(negedge iClk);
        chk("r3_sum", oSum, 4800);
        @(negedge iClk);
        fill(255);
        doReq(0, 0, 80, 60);
        repeat (5) @(negedge iClk);
        chk("r4_sum", oSum, 1224000);
        @(negedge iClk);
        fill(1);

        doReq(2, 3, 5, 4);
        repeat (5) @(negedge iClk);
        chk("b1_valid", oValid, 1);
        chk("b1_sum", oSum, 20);
        iX = 7'd1; iY = 6'd1; iW = 7'd3; iH = 6'd3;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        chk("b2_busy", oBusy, 1);
        repeat (2) @(negedge iClk);
        iX = 7'd0; iY = 6'd0; iW = 7'd2; iH = 6'd2;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (2) @(negedge iClk);
        chk("b2_valid", oValid, 1);
        chk("b2_sum", oSum, 9);
        @(negedge iClk);
        chk("b3_ignored", oBusy, 0);
        @(negedge iClk);

`ifdef IIG_RECT_BOUNDS_CHECK_EN
        doReq(75, 0, 10, 1);
        chk("bc_a", oRdreq, 0);
        repeat (3) @(negedge iClk) chk("bc_rd", oRdreq, 0);
        repeat (2) @(negedge iClk);
        chk("bc_valid", oValid, 1);
        chk("bc_sum", oSum, 0);
        chk("bc_err", oError, 1);
        @(negedge iClk);
`endif

        doReq(10, 5, 4, 3);
        @(negedge iClk);
        @(posedge iClk);
        #1 iReset = 1'b1;
        #1;
        chk("mr_busy", oBusy, 0);
        chk("mr_rdreq", oRdreq, 0);
        @(negedge iClk);
        iReset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge iClk);
            chk("mr_novalid", oValid, 0);
        end

        doReq(3, 2, 6, 5);
        for (int i = 0; i < 20 && !oValid; i++) @(negedge iClk);
        chk("fr_valid", oValid, 1);
        chk("fr_sum", oSum, 30);
        repeat (3) @(negedge iClk);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/iig_rect_sum.md
# iig_rect_sum

Rectangle-sum engine directly downstream of the integral-image generator. It is given a rectangle (top-left corner, width, height) inside the 80x60 downscaled frame and reads up to four corner words from the integral-image BRAM (IIGBRAM) read port. It combines them as D − B − C + A and returns the pixel sum of that rectangle. Haar-feature evaluation and window-variance logic use it to obtain rectangle sums in a fixed cycle count.

## Interface
Parameters:
- IMG_W, 80, frame width in pixels
- IMG_H, 60, frame height in pixels
- ADDR_W, 13, IIGBRAM address width
- DATA_W, 21, integral-image word width
- RD_LAT, 1, IIGBRAM read latency in cycles (1..3)

Ports:
- iClk  in  1  clock, all state on rising edge
- iReset  in  1  reset, asynchronous, active-high
- iStart  in  1  request pulse; sampled only when oBusy=0
- iX  in  7  rectangle left column x0
- iY  in  6  rectangle top row y0
- iW  in  7  rectangle width w
- iH  in  6  rectangle height h
- oRdreq_to_IIGBRAM  out  1  read strobe, one word per cycle
- oAddr_to_IIGBRAM  out  ADDR_W  read address = y*IMG_W + x
- iData_from_IIGBRAM  in  DATA_W  read data, valid RD_LAT cycles after its strobe
- oBusy  out  1  request in progress
- oValid  out  1  one-cycle pulse, oSum/oError valid
- oSum  out  DATA_W  rectangle sum, held until next oValid
- oError  out  1  rectangle rejected (bounds check build only)

## Operation
- Integral convention: II(x,y) = sum of pixels over [0..x]×[0..y] inclusive, stored at address y*IMG_W + x.
- Let x1 = x0+w−1 and y1 = y0+h−1. Define corners A=II(x0−1,y0−1), B=II(x1,y0−1), C=II(x0−1,y1), D=II(x1,y1).
- Sum = D − B − C + A. Any corner with a −1 coordinate contributes 0 and issues no read.
- Inputs are latched on acceptance. Later changes to iX/iY/iW/iH do not affect the request in flight.
- FSM: IDLE → SLOT_A → SLOT_B → SLOT_C → SLOT_D → DRAIN (RD_LAT cycles) → DONE → IDLE.
- Each SLOT lasts exactly one cycle. It asserts oRdreq and drives its address only when the corner exists.
- Accumulator: signed DATA_W+1 bits, cleared on acceptance. Returning data is added (A, D) or subtracted (B, C) using a sign tag pipelined RD_LAT deep.
- The final value is non-negative and fits DATA_W: 80·60·255 = 1 224 000 < 2^21. oSum is the low DATA_W bits.
- Address multiply: y*80 = (y<<6)+(y<<4), using shift-add only.

## Timing
- Reset values: oRdreq 0, oAddr 0, oBusy 0, oValid 0, oSum 0, oError 0, FSM IDLE, accumulator 0.
- iStart high in IDLE at edge k: oBusy is high from cycle k+1. Slots A..D occupy cycles k+1..k+4.
- oValid is high in cycle k+5+RD_LAT (k+6 for RD_LAT=1). Latency is fixed regardless of skipped corners.
- oBusy falls in the oValid cycle. An iStart in that same cycle is accepted, giving back-to-back throughput of 5+RD_LAT cycles.
- iStart while oBusy=1 is ignored.
- Reset asserted mid-request aborts the request immediately. No oValid is produced and all outputs return to reset values. Data still returning from the BRAM after reset is ignored.
- oRdreq is never asserted outside SLOT states.

## Configuration
- Macro: IIG_RECT_BOUNDS_CHECK_EN.
- Defined: on acceptance, the request is rejected if w=0, h=0, x0+w>IMG_W or y0+h>IMG_H. A rejected request:
  - issues no reads,
  - still follows the fixed latency,
  - produces oValid with oSum=0 and oError=1.
- Undefined: no check is made. oError is tied 0. Out-of-range requests issue whatever addresses the arithmetic yields, truncated to ADDR_W, and the result is undefined.

## Structure
- Shared package iig_pkg holds:
  - IMG_W/IMG_H defaults, ADDR_W, DATA_W
  - FSM state typedef
  - corner-sign encoding
  - the xy-to-address function, reused by the generator's address counter
- One sub-module, iig_rect_acc, contains the RD_LAT-deep valid/sign tag pipeline and the signed accumulator. The FSM and address generation stay in the top module.

## Test plan
BRAM model for all tests: RD_LAT=1, filled with the integral image of an all-ones frame, so II(x,y) = (x+1)(y+1), unless noted.
- (x0,y0,w,h)=(10,5,4,3):
  - reads at addresses 329, 333, 569, 573 in cycles k+1..k+4
  - oValid at k+6, oSum=12, oError=0
- (0,0,1,1): only slot D reads (address 0). oSum=1 at k+6.
- Full frame (0,0,80,60): single read at address 4799. oSum=4800. Repeat with a 255-valued frame: oSum=1 224 000.
- Back-to-back: second iStart in the oValid cycle is accepted. Its oValid arrives 6 cycles later. A third iStart while busy is ignored.
- With IIG_RECT_BOUNDS_CHECK_EN, (75,0,10,1): no oRdreq, oValid at k+6 with oSum=0 and oError=1.
- iReset pulsed at k+3:
  - oRdreq/oBusy drop immediately, and no oValid follows.
  - A fresh request afterwards returns the correct sum.
